// File: rtl/wb_dma_pkg.sv
// -----------------------------------------------------------------------------
// wb_dma_pkg
// Q-Channel definitions shared by the wb_dma power controller (initiator) and
// the device-side Q-Channel wrapper.
//   - q_state_e    : one-hot controller state encoding (5 bits)
//   - Q_*_BIT      : bit positions of each state inside the one-hot vector
//   - q_iface_e    : the six Q-Channel interface states, as observed on the
//                    wires {qreqn, qacceptn, qdeny}
//   - q_iface_decode() : maps the three wires onto q_iface_e
// -----------------------------------------------------------------------------
package wb_dma_pkg;

  // Bit positions inside the one-hot state vector. Outputs are taken from
  // these bits directly so they never decode through combinational logic.
  localparam int Q_RUN_BIT      = 0;
  localparam int Q_REQUEST_BIT  = 1;
  localparam int Q_STOPPED_BIT  = 2;
  localparam int Q_EXIT_BIT     = 3;
  localparam int Q_CONTINUE_BIT = 4;
  localparam int Q_STATE_W      = 5;

  typedef enum logic [Q_STATE_W-1:0] {
    Q_RUN      = 5'b00001,
    Q_REQUEST  = 5'b00010,
    Q_STOPPED  = 5'b00100,
    Q_EXIT     = 5'b01000,
    Q_CONTINUE = 5'b10000
  } q_state_e;

  // Interface-level protocol states, identical on both sides of the channel.
  typedef enum logic [2:0] {
    QI_RUN,       // qreqn=1 qacceptn=1 qdeny=0
    QI_REQUEST,   // qreqn=0 qacceptn=1 qdeny=0
    QI_STOPPED,   // qreqn=0 qacceptn=0 qdeny=0
    QI_EXIT,      // qreqn=1 qacceptn=0 qdeny=0
    QI_DENIED,    // qreqn=0 qacceptn=1 qdeny=1
    QI_CONTINUE,  // qreqn=1 qacceptn=1 qdeny=1
    QI_ILLEGAL    // qacceptn=0 together with qdeny=1
  } q_iface_e;

  function automatic q_iface_e q_iface_decode(input logic qreqn,
                                              input logic qacceptn,
                                              input logic qdeny);
    q_iface_e s;
    s = QI_ILLEGAL;
    unique case ({qreqn, qacceptn, qdeny})
      3'b110:  s = QI_RUN;
      3'b010:  s = QI_REQUEST;
      3'b000:  s = QI_STOPPED;
      3'b100:  s = QI_EXIT;
      3'b011:  s = QI_DENIED;
      3'b111:  s = QI_CONTINUE;
      default: s = QI_ILLEGAL;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/wb_dma_idle_cnt.sv
// -----------------------------------------------------------------------------
// wb_dma_idle_cnt
// Saturating idle-cycle counter with threshold comparator.
//   clk_i      : system clock
//   rst_ni     : synchronous active-low reset
//   run_i      : 1 while the controller is in Q_RUN; counter is held at zero
//                otherwise, so every entry into Q_RUN starts a full period
//   activity_i : system busy; clears the counter
//   thresh_i   : idle threshold, 0 disables the comparator
//   cnt_o      : current idle count
//   hit_o      : count has reached a non-zero threshold
// -----------------------------------------------------------------------------
module wb_dma_idle_cnt #(
  parameter int IDLE_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              run_i,
  input  logic              activity_i,
  input  logic [IDLE_W-1:0] thresh_i,
  output logic [IDLE_W-1:0] cnt_o,
  output logic              hit_o
);

  logic [IDLE_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its inputs regardless of block evaluation order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (!run_i || activity_i) begin
      cnt_q <= '0;
    end else if (cnt_q != {IDLE_W{1'b1}}) begin
      cnt_q <= cnt_q + IDLE_W'(1);
    end
  end

  // Compared against the live threshold, so lowering it below the current
  // count fires on the very next cycle.
  assign hit_o = (thresh_i != '0) && (cnt_q >= thresh_i);
  assign cnt_o = cnt_q;

endmodule

// File: rtl/wb_dma_qctrl.sv
// -----------------------------------------------------------------------------
// wb_dma_qctrl
// Q-Channel initiator for the wb_dma device. Requests quiescence after a
// programmable idle period, handles accept / deny / wake, and drives the
// device clock-gate enable.
//   clk_i         : system clock (same domain as the device)
//   rst_ni        : synchronous active-low reset
//   pwr_en_i      : auto power-down enable; 0 blocks requests, wakes device
//   idle_thresh_i : idle cycles before a request, 0 disables auto-request
//   activity_i    : system busy indication
//   wake_i        : explicit wake request
//   qreqn_o       : Q-Channel request (active-low), registered
//   qacceptn_i    : device accept (active-low)
//   qdeny_i       : device deny
//   clk_en_o      : device clock-gate enable, low only while stopped
//   stopped_o     : high while in Q_STOPPED
//   deny_cnt_o    : saturating count of denied requests
//   prot_err_o    : sticky illegal-handshake flag
// -----------------------------------------------------------------------------
module wb_dma_qctrl
  import wb_dma_pkg::*;
#(
  parameter int IDLE_W = 8,
  parameter int DENY_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              pwr_en_i,
  input  logic [IDLE_W-1:0] idle_thresh_i,
  input  logic              activity_i,
  input  logic              wake_i,
  output logic              qreqn_o,
  input  logic              qacceptn_i,
  input  logic              qdeny_i,
  output logic              clk_en_o,
  output logic              stopped_o,
  output logic [DENY_W-1:0] deny_cnt_o,
  output logic              prot_err_o
);

  q_state_e          state_q, state_d;
  logic              qreqn_q;
  logic [DENY_W-1:0] deny_cnt_q;
  logic              prot_err_q;
  logic              deny_inc;
  logic              err_set;
  logic [IDLE_W-1:0] idle_cnt;
  logic              idle_hit;

  wb_dma_idle_cnt #(
    .IDLE_W (IDLE_W)
  ) u_idle_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .run_i      (state_q[Q_RUN_BIT]),
    .activity_i (activity_i),
    .thresh_i   (idle_thresh_i),
    .cnt_o      (idle_cnt),
    .hit_o      (idle_hit)
  );

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d  = state_q;
    deny_inc = 1'b0;
    err_set  = 1'b0;
    unique case (state_q)
      Q_RUN: begin
        // A device answer while no request is outstanding is illegal; hold.
        if (!qacceptn_i || qdeny_i) begin
          err_set = 1'b1;
        end else if (pwr_en_i && idle_hit && !activity_i) begin
          state_d = Q_REQUEST;
        end
      end
      Q_REQUEST: begin
        // Request cannot be withdrawn; only the device moves us on.
        if (!qacceptn_i) begin
          state_d = Q_STOPPED;
          err_set = qdeny_i;
        end else if (qdeny_i) begin
          state_d  = Q_CONTINUE;
          deny_inc = 1'b1;
        end
      end
      Q_STOPPED: begin
        if (qdeny_i || qacceptn_i) begin
          err_set = 1'b1;
        end else if (wake_i || activity_i || !pwr_en_i) begin
          state_d = Q_EXIT;
        end
      end
      Q_EXIT: begin
        if (qdeny_i) begin
          err_set = 1'b1;
        end else if (qacceptn_i) begin
          state_d = Q_RUN;
        end
      end
      Q_CONTINUE: begin
        if (!qdeny_i) begin
          state_d = Q_RUN;
        end
      end
      default: state_d = Q_EXIT;
    endcase
  end

  // NOTE: the reset state is Q_EXIT, not Q_RUN: the device comes out of its
  // own reset stopped (qacceptn=0), so the first handshake is an exit.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= Q_EXIT;
      qreqn_q    <= 1'b1;
      deny_cnt_q <= '0;
      prot_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Registered from the next state so qreqn_o is a single flop output.
      qreqn_q <= !(state_d == Q_REQUEST || state_d == Q_STOPPED);
      if (deny_inc && deny_cnt_q != {DENY_W{1'b1}}) begin
        deny_cnt_q <= deny_cnt_q + DENY_W'(1);
      end
      if (err_set) begin
        prot_err_q <= 1'b1;
      end
    end
  end

  assign qreqn_o    = qreqn_q;
  assign stopped_o  = state_q[Q_STOPPED_BIT];
  assign clk_en_o   = !state_q[Q_STOPPED_BIT];
  assign deny_cnt_o = deny_cnt_q;
  assign prot_err_o = prot_err_q;

endmodule
